// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset PC, instruction access size, address type.
package cpu_defs;
    typedef logic [31:0] addr_t;

    localparam addr_t      PC_RESET       = 32'h1c000000;
    localparam logic [1:0] INST_SIZE_WORD = 2'b10;
endpackage

// File: rtl/pfs_redirect_buf.sv
// Holds one pending redirect target; a load overwrites any older entry.
module pfs_redirect_buf
    import cpu_defs::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  addr_t load_target,
    input  logic  clear,
    output logic  valid,
    output addr_t target
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= 1'b0;
            target <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            target <= load_target;
        end else if (clear) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/pre_if_stage.sv
// Pre-IF stage: next-PC selection and address phase of the instruction
// sram-like interface, with request locking and redirect buffering.
module pre_if_stage #(
    parameter logic [31:0] PC_RESET = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    input  logic [31:0] fs_pc,
    input  logic        fs_pc_valid,
    input  logic        wb_ex,
    input  logic [31:0] ex_entry,
    input  logic        ertn_flush,
    input  logic [31:0] ertn_entry,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_stall,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    output logic        pfs_to_fs_valid,
    output logic [31:0] pfs_pc,
    output logic        pfs_discard
);
    import cpu_defs::*;

    logic  redir;
    addr_t redir_pc;
    addr_t cand;
    logic  start;
    logic  accept;
    logic  lock;
    addr_t lock_addr;
    logic  stale;
    logic  buf_valid;
    addr_t buf_target;
    logic  buf_load;
    logic  buf_clear;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = INST_SIZE_WORD;
    assign inst_sram_wstrb = '0;
    assign inst_sram_wdata = '0;

    // Redirect priority: exception > ertn > branch.
    always_comb begin
        redir    = wb_ex | ertn_flush | br_taken;
        redir_pc = br_target;
        if (ertn_flush) redir_pc = ertn_entry;
        if (wb_ex)      redir_pc = ex_entry;
    end

    always_comb begin
        if (redir)             cand = redir_pc;
        else if (buf_valid)    cand = buf_target;
        else if (!fs_pc_valid) cand = PC_RESET;
        else                   cand = fs_pc + 32'd4;
    end

    assign start           = !lock && fs_allowin && (!br_stall || wb_ex || ertn_flush) && !reset;
    assign inst_sram_req   = (lock || start) && !reset;
    assign inst_sram_addr  = lock ? lock_addr : cand;
    assign accept          = inst_sram_req && inst_sram_addr_ok;
    assign pfs_to_fs_valid = accept;
    assign pfs_pc          = inst_sram_addr;
    assign pfs_discard     = accept && lock && (stale || redir);

    // Buffer is dropped when an unlocked request starts rather than on its
    // accept: if that request locks, any later redirect reloads the buffer.
    assign buf_load  = lock && redir;
    assign buf_clear = !lock && (redir || start);

    always_ff @(posedge clk) begin
        if (reset) begin
            lock      <= 1'b0;
            lock_addr <= '0;
            stale     <= 1'b0;
        end else begin
            if (inst_sram_req && !inst_sram_addr_ok) begin
                lock      <= 1'b1;
                lock_addr <= inst_sram_addr;
            end else if (inst_sram_addr_ok) begin
                lock      <= 1'b0;
            end
            if (accept)              stale <= 1'b0;
            else if (lock && redir)  stale <= 1'b1;
        end
    end

    pfs_redirect_buf u_redirect_buf (
        .clk         (clk),
        .reset       (reset),
        .load        (buf_load),
        .load_target (redir_pc),
        .clear       (buf_clear),
        .valid       (buf_valid),
        .target      (buf_target)
    );

endmodule

// File: tb/tb_pre_if_stage.sv
// Directed bench for pre_if_stage with a minimal fetch-stage model driving fs_pc.
module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin;
    logic [31:0] fs_pc;
    logic        fs_pc_valid;
    logic        wb_ex;
    logic [31:0] ex_entry;
    logic        ertn_flush;
    logic [31:0] ertn_entry;
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_stall;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        pfs_to_fs_valid;
    logic [31:0] pfs_pc;
    logic        pfs_discard;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    pre_if_stage #(.PC_RESET(32'h1c000000)) dut (
        .clk               (clk),
        .reset             (reset),
        .fs_allowin        (fs_allowin),
        .fs_pc             (fs_pc),
        .fs_pc_valid       (fs_pc_valid),
        .wb_ex             (wb_ex),
        .ex_entry          (ex_entry),
        .ertn_flush        (ertn_flush),
        .ertn_entry        (ertn_entry),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .br_stall          (br_stall),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .pfs_to_fs_valid   (pfs_to_fs_valid),
        .pfs_pc            (pfs_pc),
        .pfs_discard       (pfs_discard)
    );

    // Fetch stage: takes every non-discarded accepted PC as its sequential base.
    always @(posedge clk) begin
        if (reset) begin
            fs_pc_valid <= 1'b0;
            fs_pc       <= 32'h0;
        end else if (pfs_to_fs_valid && !pfs_discard) begin
            fs_pc_valid <= 1'b1;
            fs_pc       <= pfs_pc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Checks outputs of the current cycle (inputs already applied), then
    // advances to the next negedge. Address only checked while requesting.
    task automatic cyc(input string tag, input logic e_req, input logic [31:0] e_addr,
                       input logic e_val, input logic e_disc);
        #1;
        chk({tag, ".req"}, {31'b0, inst_sram_req}, {31'b0, e_req});
        if (e_req) begin
            chk({tag, ".addr"}, inst_sram_addr, e_addr);
            chk({tag, ".pfs_pc"}, pfs_pc, e_addr);
        end
        chk({tag, ".valid"}, {31'b0, pfs_to_fs_valid}, {31'b0, e_val});
        chk({tag, ".discard"}, {31'b0, pfs_discard}, {31'b0, e_disc});
        @(negedge clk);
    endtask

    task automatic no_redir();
        wb_ex = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fs_allowin = 1'b1; br_stall = 1'b0; inst_sram_addr_ok = 1'b1;
        ex_entry = 32'h0; ertn_entry = 32'h0; br_target = 32'h0;
        no_redir();
        @(negedge clk);

        // Reset cycles
        cyc("rst0", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("const.wr",    {31'b0, inst_sram_wr}, 32'h0);
        chk("const.size",  {30'b0, inst_sram_size}, 32'h2);
        chk("const.wstrb", {28'b0, inst_sram_wstrb}, 32'h0);
        chk("const.wdata", inst_sram_wdata, 32'h0);
        cyc("rst1", 1'b0, 32'h0, 1'b0, 1'b0);

        // Streaming from reset PC
        reset = 1'b0;
        cyc("seq0", 1'b1, 32'h1c000000, 1'b1, 1'b0);
        cyc("seq1", 1'b1, 32'h1c000004, 1'b1, 1'b0);

        // addr_ok stalls three cycles
        inst_sram_addr_ok = 1'b0;
        cyc("hold0", 1'b1, 32'h1c000008, 1'b0, 1'b0);
        cyc("hold1", 1'b1, 32'h1c000008, 1'b0, 1'b0);
        cyc("hold2", 1'b1, 32'h1c000008, 1'b0, 1'b0);
        inst_sram_addr_ok = 1'b1;
        cyc("hold3", 1'b1, 32'h1c000008, 1'b1, 1'b0);
        cyc("seq2",  1'b1, 32'h1c00000c, 1'b1, 1'b0);

        // Branch while locked at 0x10
        inst_sram_addr_ok = 1'b0;
        cyc("lk10", 1'b1, 32'h1c000010, 1'b0, 1'b0);
        br_taken = 1'b1; br_target = 32'h1c000100;
        cyc("lk10br", 1'b1, 32'h1c000010, 1'b0, 1'b0);
        no_redir(); inst_sram_addr_ok = 1'b1;
        cyc("stale10", 1'b1, 32'h1c000010, 1'b1, 1'b1);
        cyc("buf100", 1'b1, 32'h1c000100, 1'b1, 1'b0);

        // Branch then exception while locked: last writer wins
        inst_sram_addr_ok = 1'b0;
        cyc("lk104", 1'b1, 32'h1c000104, 1'b0, 1'b0);
        br_taken = 1'b1; br_target = 32'h1c000200;
        cyc("lk104br", 1'b1, 32'h1c000104, 1'b0, 1'b0);
        no_redir(); wb_ex = 1'b1; ex_entry = 32'h1c008000;
        cyc("lk104ex", 1'b1, 32'h1c000104, 1'b0, 1'b0);
        no_redir(); inst_sram_addr_ok = 1'b1;
        cyc("stale104", 1'b1, 32'h1c000104, 1'b1, 1'b1);
        cyc("buf8000", 1'b1, 32'h1c008000, 1'b1, 1'b0);
        cyc("seq8004", 1'b1, 32'h1c008004, 1'b1, 1'b0);

        // Same-cycle exception and branch while unlocked
        wb_ex = 1'b1; ex_entry = 32'h1c00a000; br_taken = 1'b1; br_target = 32'h1c000300;
        cyc("exbr", 1'b1, 32'h1c00a000, 1'b1, 1'b0);
        no_redir();

        // br_stall and fs_allowin gating
        br_stall = 1'b1;
        cyc("stall", 1'b0, 32'h0, 1'b0, 1'b0);
        br_taken = 1'b1; br_target = 32'h1c000500;
        cyc("stallbr", 1'b0, 32'h0, 1'b0, 1'b0);
        no_redir(); wb_ex = 1'b1; ex_entry = 32'h1c00c000;
        cyc("stallex", 1'b1, 32'h1c00c000, 1'b1, 1'b0);
        no_redir(); br_stall = 1'b0; fs_allowin = 1'b0;
        cyc("noallow", 1'b0, 32'h0, 1'b0, 1'b0);
        fs_allowin = 1'b1;
        cyc("seqc004", 1'b1, 32'h1c00c004, 1'b1, 1'b0);

        // Reset while locked with buffer valid
        inst_sram_addr_ok = 1'b0;
        cyc("lkc008", 1'b1, 32'h1c00c008, 1'b0, 1'b0);
        br_taken = 1'b1; br_target = 32'h1c000400;
        cyc("lkc008br", 1'b1, 32'h1c00c008, 1'b0, 1'b0);
        no_redir(); reset = 1'b1; inst_sram_addr_ok = 1'b1;
        cyc("rstlk", 1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        cyc("post0", 1'b1, 32'h1c000000, 1'b1, 1'b0);
        cyc("post1", 1'b1, 32'h1c000004, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Pre-IF stage, directly upstream of the fetch stage. Owns next-PC selection and the address phase of the sram-like instruction interface (req/addr_ok).
- Holds each request stable until accepted. Buffers redirects (exception, ertn, branch) that arrive while a request is locked.
- Tags stale requests so the fetch stage discards their returned data.
- Data phase (data_ok/rdata) is handled by the fetch stage and is out of scope here.

Parameters:
- PC_RESET, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fs_allowin  in  1  fetch stage can accept a new request this cycle.
- fs_pc  in  32  PC currently held in fetch; sequential base.
- fs_pc_valid  in  1  fs_pc is valid (low after reset until first hand-off).
- wb_ex  in  1  exception redirect.
- ex_entry  in  32  exception target.
- ertn_flush  in  1  ertn redirect.
- ertn_entry  in  32  ertn target.
- br_taken  in  1  branch redirect.
- br_target  in  32  branch target.
- br_stall  in  1  branch in decode not yet resolvable; do not start a new request.
- inst_sram_req  out  1  request valid.
- inst_sram_wr  out  1  constant 0.
- inst_sram_size  out  2  constant 2'b10.
- inst_sram_wstrb  out  4  constant 0.
- inst_sram_addr  out  32  request address.
- inst_sram_wdata  out  32  constant 0.
- inst_sram_addr_ok  in  1  address accepted.
- pfs_to_fs_valid  out  1  request accepted this cycle; single-cycle pulse.
- pfs_pc  out  32  PC of the accepted request.
- pfs_discard  out  1  accepted request is stale; fetch must drop its data.

Behaviour:
- Reset (cycle with reset=1):
  - inst_sram_req=0, pfs_to_fs_valid=0, pfs_discard=0.
  - Lock, stale flag and redirect buffer cleared.
  - pfs_pc and inst_sram_addr are don't-care.
- Redirect priority, evaluated combinationally each cycle: wb_ex > ertn_flush > br_taken.
  - redir = OR of the three; redir_pc = target of the highest-priority asserted source.
- Candidate next PC, in priority order:
  - redir_pc if redir;
  - else buffered target if buffer valid;
  - else PC_RESET if !fs_pc_valid;
  - else fs_pc+4 (modulo 2^32).
- Start condition: start = !lock && fs_allowin && !br_stall && !reset.
  - wb_ex or ertn_flush override br_stall; br_taken does not.
- inst_sram_req = lock | start.
- Address:
  - Unlocked: inst_sram_addr = candidate (same-cycle redirect takes effect with zero latency).
  - Locked: inst_sram_addr = lock_addr register.
- Lock: set when req && !addr_ok; lock_addr <= inst_sram_addr. Cleared on addr_ok. Address is never changed while locked.
- Handshake: pfs_to_fs_valid = inst_sram_req && inst_sram_addr_ok; pfs_pc = inst_sram_addr.
  - Fetch stage contract: any request started under fs_allowin=1 is captured on its accept pulse.
- Stale marking: a redirect (redir=1) in any cycle while locked, including the accept cycle, sets stale.
  - The locked request, when accepted, gets pfs_discard=1. Stale clears on accept.
- Redirect buffer:
  - Loaded with redir_pc when redir and the redirect cannot be applied to the address this cycle (locked).
  - A newer redirect overwrites the buffer (last-writer wins; same-cycle priority as above).
  - Cleared when a request using the buffered target is accepted.
  - Redirect while unlocked is applied directly; buffer untouched, or cleared if it was valid.
- Simultaneous events:
  - Locked accept and redirect in the same cycle: pfs_discard=1, buffer loaded; next request uses the buffer.
  - Unlocked start and redirect in the same cycle: address = redir_pc, pfs_discard=0.
- Reset mid-lock: lock, stale and buffer dropped at once. req=0 in the reset cycle (interface reset together).
- Throughput: one accepted request per cycle when addr_ok is held at 1 and fs_allowin=1.

Decomposition:
- Shared package (cpu_defs): PC_RESET, INST_SIZE_WORD=2'b10.
- Sub-module pfs_redirect_buf holds {valid, target} with load/overwrite/clear. Remaining logic stays in pre_if_stage.

Test Plan:
- Reset release, addr_ok=1, fs_allowin=1 -> first req addr 0x1c000000, then 0x1c000004 each cycle, pfs_discard=0.
- addr_ok low 3 cycles while fs_pc advances -> addr stable at 0x1c000008 for 4 cycles, one pfs_to_fs_valid pulse.
- Locked at 0x1c000010, br_taken to 0x1c000100 for 1 cycle, addr_ok next cycle -> accept of 0x1c000010 with pfs_discard=1; next req 0x1c000100 with discard=0.
- Locked; br_taken(0x1c000200) then wb_ex(ex_entry=0x1c008000) in later cycle before accept -> stale accept, next req 0x1c008000.
- Same cycle wb_ex and br_taken while unlocked -> addr=ex_entry, no discard; br_stall=1 without redirect -> req stays 0.
- reset asserted while locked and buffer valid -> req=0 that cycle; after release first addr 0x1c000000, discard=0.
